alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Execute-stage sequencer for the ALU op set (add, sub, xor, or, and, sll, srl, sra, slt, sltu). It accepts decoded ALU ops from decode over a valid/ready handshake and drives a one-hot enable to the op units. It captures the OR-merged unit result into an output register and presents it to writeback over a second valid/ready handshake. It is a two-stage pipeline (issue, result) with full throughput, backpressure, flush and a retired-op counter.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; drops all in-flight ops
- in_valid  in  1  decode has an op
- in_ready  out  1  controller accepts this cycle
- in_funct3  in  3  RV32I funct3
- in_f7b5  in  1  instruction bit 30
- in_is_imm  in  1  OP-IMM form
- in_a, in_b  in  32  operands (in_b = immediate when is_imm)
- in_rd  in  5  destination register
- op_en  out  10  one-hot unit enables: [0]add [1]sub [2]xor [3]or [4]and [5]sll [6]srl [7]sra [8]slt [9]sltu
- op_a, op_b  out  32  operands to all units
- op_rslt  in  32  OR of all unit outputs (disabled units output 0)
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts
- out_data  out  32  result
- out_rd  out  5  destination
- out_illegal  out  1  op was undecodable
- retire_cnt  out  32  count of legal ops handed to writeback

## Operation
- Decode at accept, stored in issue stage as 10-bit one-hot plus illegal flag.
  - funct3 000: sub if !is_imm && f7b5, else add.
  - 001: sll. 010: slt. 011: sltu. 100: xor. 110: or. 111: and.
  - 101: sra if f7b5, else srl.
  - Illegal when !is_imm && f7b5 && funct3 not in {000,101}, or is_imm && f7b5 && funct3==001. Illegal ops get op_en=0 and carry illegal=1.
- Issue stage (iv): holds a, b, rd, one-hot, illegal.
  - op_en = one-hot & {10{iv}}; op_a/op_b are driven from the issue registers.
- Result stage (rv): captures op_rslt, rd, illegal when the issue stage advances. Illegal ops capture 0.
- Occupancy states {iv,rv}: EMPTY(00), ISSUE(10), DONE(01), FULL(11).
  - adv_r = rv && out_ready.
  - adv_i = iv && (!rv || adv_r).
  - in_ready = !iv || adv_i; this is combinational and has no dependence on in_valid.
- Transitions:
  - iv_next = (in_valid && in_ready) || (iv && !adv_i).
  - rv_next = adv_i || (rv && !adv_r).
- retire_cnt increments by 1 on adv_r when the result stage is not illegal. It wraps 0xFFFFFFFF -> 0.
- Flush clears iv and rv next edge. A same-cycle accept is discarded. A same-cycle out handshake still counts. retire_cnt is kept.

## Timing
- Reset values:
  - iv=rv=0, so out_valid=0, op_en=0.
  - in_ready=1, out_data=0, out_rd=0, out_illegal=0, retire_cnt=0, op_a=op_b=0.
- Latency: accept at edge T, op_en active during cycle T..T+1, result captured at edge T+1, out_valid high from T+1 after that edge (two edges accept-to-valid).
- Throughput: one op per cycle while out_ready=1.
- Backpressure: out_valid/out_data/out_rd/out_illegal are held stable until handshake.
  - Issue-stage registers and op_en are held while stalled.
  - in_ready=0 only in FULL with out_ready=0.
- Simultaneous handshake in FULL: result drains, issue advances and new op accepted in the same edge.
- Reset mid-operation drops everything immediately (async), with no partial output.

## Test plan
- Reset, then add a=5 b=7 (f3=000, reg), out_ready=1 -> op_en=0x001 during the issue cycle; out_valid two edges after accept with out_data=12, rd passed through; retire_cnt=1.
- Back-to-back sub 3-5, sra 0x80000000>>4 (f3=101 f7b5=1), sltu 1<0xFFFFFFFF -> outputs 0xFFFFFFFE, 0xF8000000, 1 on consecutive cycles; op_en 0x002, 0x080, 0x200.
- Backpressure: out_ready=0 for 5 cycles with 3 ops offered -> in_ready drops after 2 accepted; out_data stable; release yields ops in order, no loss or duplication.
- Illegal: reg f3=100 f7b5=1 -> op_en=0, out_illegal=1, out_data=0, retire_cnt unchanged. OP-IMM f3=000 f7b5=1 -> addi legal.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale result ever presented.
- Async rst asserted mid-cycle in FULL -> outputs reach reset values without a clock edge. Preload retire_cnt near wrap via 2^32 ops or force -> wraps to 0.

Source files
------------

// File: rtl/alu_issue_if.sv
// Bundles the decode-side, unit-side and writeback-side signals of the ALU issue controller.
// The slave modport is the controller's view; master is the surrounding pipeline's view.
`timescale 1ns/1ps
interface alu_issue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic        in_is_imm;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic [9:0]  op_en;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_rslt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic [31:0] retire_cnt;

  modport slave (
    input  flush, in_valid, in_funct3, in_f7b5, in_is_imm, in_a, in_b, in_rd,
    input  op_rslt, out_ready,
    output in_ready, op_en, op_a, op_b, out_valid, out_data, out_rd, out_illegal,
    output retire_cnt
  );

  modport master (
    output flush, in_valid, in_funct3, in_f7b5, in_is_imm, in_a, in_b, in_rd,
    output op_rslt, out_ready,
    input  in_ready, op_en, op_a, op_b, out_valid, out_data, out_rd, out_illegal,
    input  retire_cnt
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Two-stage (issue, result) execute sequencer for the RV32I ALU op set.
// Drives a one-hot unit enable from the issue stage and registers the OR-merged unit result.
`timescale 1ns/1ps
module alu_issue_ctrl (
  input logic       clk,
  input logic       rst,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    DONE  = 2'b01,
    ISSUE = 2'b10,
    FULL  = 2'b11
  } occ_e;

  occ_e        state, state_nx;
  logic        iv, rv;
  logic        adv_i, adv_r, in_rdy, accept;
  logic [9:0]  dec_oh;
  logic        dec_ill;

  logic [31:0] a_q, b_q;
  logic [4:0]  rd_q;
  logic [9:0]  oh_q;
  logic        ill_q;

  logic [31:0] rdata_q;
  logic [4:0]  rrd_q;
  logic        rill_q;
  logic [31:0] cnt;

  // Decode funct3/f7b5/is_imm into a unit one-hot; undecodable ops get no enable.
  always_comb begin
    dec_oh  = '0;
    dec_ill = (!bus.in_is_imm && bus.in_f7b5 &&
               (bus.in_funct3 != 3'b000) && (bus.in_funct3 != 3'b101)) ||
              (bus.in_is_imm && bus.in_f7b5 && (bus.in_funct3 == 3'b001));
    case (bus.in_funct3)
      3'b000:  dec_oh = (!bus.in_is_imm && bus.in_f7b5) ? 10'h002 : 10'h001;
      3'b001:  dec_oh = 10'h020;
      3'b010:  dec_oh = 10'h100;
      3'b011:  dec_oh = 10'h200;
      3'b100:  dec_oh = 10'h004;
      3'b101:  dec_oh = bus.in_f7b5 ? 10'h080 : 10'h040;
      3'b110:  dec_oh = 10'h008;
      default: dec_oh = 10'h010;
    endcase
    if (dec_ill) dec_oh = '0;
  end

  // Occupancy state register: bit 1 is the issue stage, bit 0 the result stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    iv       = state[1];
    rv       = state[0];
    adv_r    = rv && bus.out_ready;
    adv_i    = iv && (!rv || adv_r);
    in_rdy   = !iv || adv_i;
    accept   = bus.in_valid && in_rdy;
    state_nx = occ_e'({accept || (iv && !adv_i), adv_i || (rv && !adv_r)});
    if (bus.flush) state_nx = EMPTY;
  end

  // Issue-stage payload only loads on accept, so it holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      oh_q  <= '0;
      ill_q <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.in_a;
      b_q   <= bus.in_b;
      rd_q  <= bus.in_rd;
      oh_q  <= dec_oh;
      ill_q <= dec_ill;
    end
  end

  // Result capture plus retire count; an out handshake still retires during a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rrd_q   <= '0;
      rill_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (adv_i) begin
        rdata_q <= ill_q ? 32'd0 : bus.op_rslt;
        rrd_q   <= rd_q;
        rill_q  <= ill_q;
      end
      if (adv_r && !rill_q) cnt <= cnt + 32'd1;
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.op_en       = oh_q & {10{iv}};
  assign bus.op_a        = a_q;
  assign bus.op_b        = b_q;
  assign bus.out_valid   = rv;
  assign bus.out_data    = rdata_q;
  assign bus.out_rd      = rrd_q;
  assign bus.out_illegal = rill_q;
  assign bus.retire_cnt  = cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural op units feed op_rslt, a scoreboard
// queue holds reference results pushed at accept and popped at the writeback handshake.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_asserts = 0;
  int   n_fails   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] held;

  alu_issue_if bus ();

  alu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU units; disabled units contribute zero to the merged result.
  always_comb begin
    bus.op_rslt = '0;
    if (bus.op_en[0]) bus.op_rslt |= bus.op_a + bus.op_b;
    if (bus.op_en[1]) bus.op_rslt |= bus.op_a - bus.op_b;
    if (bus.op_en[2]) bus.op_rslt |= bus.op_a ^ bus.op_b;
    if (bus.op_en[3]) bus.op_rslt |= bus.op_a | bus.op_b;
    if (bus.op_en[4]) bus.op_rslt |= bus.op_a & bus.op_b;
    if (bus.op_en[5]) bus.op_rslt |= bus.op_a << bus.op_b[4:0];
    if (bus.op_en[6]) bus.op_rslt |= bus.op_a >> bus.op_b[4:0];
    if (bus.op_en[7]) bus.op_rslt |= 32'($signed(bus.op_a) >>> bus.op_b[4:0]);
    if (bus.op_en[8]) bus.op_rslt |= {31'd0, $signed(bus.op_a) < $signed(bus.op_b)};
    if (bus.op_en[9]) bus.op_rslt |= {31'd0, bus.op_a < bus.op_b};
  end

  function automatic exp_t ref_op(input logic [2:0] f3, input logic f7, input logic imm,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd);
    exp_t e;
    e.rd  = rd;
    e.ill = (!imm && f7 && f3 != 3'b000 && f3 != 3'b101) || (imm && f7 && f3 == 3'b001);
    case (f3)
      3'b000:  e.data = (!imm && f7) ? a - b : a + b;
      3'b001:  e.data = a << b[4:0];
      3'b010:  e.data = {31'd0, $signed(a) < $signed(b)};
      3'b011:  e.data = {31'd0, a < b};
      3'b100:  e.data = a ^ b;
      3'b101:  e.data = f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  e.data = a | b;
      default: e.data = a & b;
    endcase
    if (e.ill) e.data = '0;
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] f3, input logic f7, input logic imm,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f3;
    bus.in_f7b5   = f7;
    bus.in_is_imm = imm;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_rd     = rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    check_output(tag, 32'(sb.size()), 32'd0);
  endtask

  // Monitor on the falling edge: pop at writeback handshake, push at accept.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_output("spurious_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_output("sb_out_data", bus.out_data, mon_e.data);
          check_output("sb_out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
          check_output("sb_out_illegal", 32'(bus.out_illegal), 32'(mon_e.ill));
        end
      end
      if (bus.flush) sb.delete();
      else if (bus.in_valid && bus.in_ready)
        sb.push_back(ref_op(bus.in_funct3, bus.in_f7b5, bus.in_is_imm,
                            bus.in_a, bus.in_b, bus.in_rd));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_funct3 = '0;
    bus.in_f7b5   = 1'b0;
    bus.in_is_imm = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b1;
    #3;
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("rst_op_en", 32'(bus.op_en), 32'd0);
    check_output("rst_out_data", bus.out_data, 32'd0);
    check_output("rst_retire_cnt", bus.retire_cnt, 32'd0);
    check_output("rst_op_a", bus.op_a, 32'd0);
    tick();
    rst = 1'b0;

    // Single add, two edges from accept to out_valid.
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 5'd3);
    tick();
    idle();
    check_output("add_op_en", 32'(bus.op_en), 32'h001);
    check_output("add_op_a", bus.op_a, 32'd5);
    check_output("add_valid_early", 32'(bus.out_valid), 32'd0);
    tick();
    check_output("add_out_valid", 32'(bus.out_valid), 32'd1);
    check_output("add_out_data", bus.out_data, 32'd12);
    check_output("add_out_rd", 32'(bus.out_rd), 32'd3);
    tick();
    check_output("add_retire", bus.retire_cnt, 32'd1);

    // Back-to-back sub, sra, sltu at full throughput.
    apply_stimulus(3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 5'd1);
    tick();
    apply_stimulus(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 5'd2);
    check_output("b2b_op_en_sub", 32'(bus.op_en), 32'h002);
    tick();
    apply_stimulus(3'b011, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 5'd4);
    check_output("b2b_op_en_sra", 32'(bus.op_en), 32'h080);
    check_output("b2b_data_sub", bus.out_data, 32'hFFFF_FFFE);
    tick();
    idle();
    check_output("b2b_op_en_sltu", 32'(bus.op_en), 32'h200);
    check_output("b2b_data_sra", bus.out_data, 32'hF800_0000);
    tick();
    check_output("b2b_data_sltu", bus.out_data, 32'd1);
    tick();
    check_output("b2b_retire", bus.retire_cnt, 32'd4);

    // Backpressure: three ops offered while writeback stalls for five cycles.
    bus.out_ready = 1'b0;
    apply_stimulus(3'b100, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 5'd5);
    tick();
    apply_stimulus(3'b110, 1'b0, 1'b0, 32'h1200_0000, 32'h0000_0034, 5'd6);
    check_output("bp_in_ready_one", 32'(bus.in_ready), 32'd1);
    tick();
    apply_stimulus(3'b111, 1'b0, 1'b0, 32'hFFFF_00FF, 32'h0F0F_0F0F, 5'd7);
    held = 32'h0000_FF00;
    for (int i = 0; i < 3; i++) begin
      check_output("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
      check_output("bp_data_hold", bus.out_data, held);
      check_output("bp_op_en_hold", 32'(bus.op_en), 32'h008);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check_output("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    drain("bp_drain");
    check_output("bp_retire", bus.retire_cnt, 32'd7);

    // Illegal register op, then legal addi with f7b5 set.
    apply_stimulus(3'b100, 1'b1, 1'b0, 32'd1, 32'd2, 5'd6);
    tick();
    idle();
    check_output("ill_op_en", 32'(bus.op_en), 32'd0);
    tick();
    check_output("ill_out_illegal", 32'(bus.out_illegal), 32'd1);
    check_output("ill_out_data", bus.out_data, 32'd0);
    tick();
    check_output("ill_retire", bus.retire_cnt, 32'd7);
    apply_stimulus(3'b000, 1'b1, 1'b1, 32'd10, 32'd5, 5'd7);
    tick();
    idle();
    check_output("addi_op_en", 32'(bus.op_en), 32'h001);
    tick();
    check_output("addi_out_illegal", 32'(bus.out_illegal), 32'd0);
    check_output("addi_out_data", bus.out_data, 32'd15);
    tick();
    check_output("addi_retire", bus.retire_cnt, 32'd8);

    // Flush while FULL with a new op offered.
    bus.out_ready = 1'b0;
    apply_stimulus(3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 5'd8);
    tick();
    apply_stimulus(3'b110, 1'b0, 1'b0, 32'd2, 32'd4, 5'd9);
    tick();
    apply_stimulus(3'b100, 1'b0, 1'b0, 32'd3, 32'd5, 5'd10);
    bus.flush = 1'b1;
    check_output("fl_full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    idle();
    check_output("fl_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("fl_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("fl_op_en", 32'(bus.op_en), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("fl_no_stale", 32'(bus.out_valid), 32'd0);
    end
    check_output("fl_retire", bus.retire_cnt, 32'd8);

    // Asynchronous reset mid-cycle while FULL.
    bus.out_ready = 1'b0;
    apply_stimulus(3'b001, 1'b0, 1'b0, 32'd1, 32'd3, 5'd11);
    tick();
    apply_stimulus(3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd12);
    tick();
    idle();
    check_output("ar_full_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check_output("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("ar_in_ready", 32'(bus.in_ready), 32'd1);
    check_output("ar_op_en", 32'(bus.op_en), 32'd0);
    check_output("ar_out_data", bus.out_data, 32'd0);
    check_output("ar_out_rd", 32'(bus.out_rd), 32'd0);
    check_output("ar_retire", bus.retire_cnt, 32'd0);
    check_output("ar_op_a", bus.op_a, 32'd0);
    tick();
    rst = 1'b0;

    // Retire counter wrap from a preloaded all-ones value.
    bus.out_ready = 1'b1;
    force dut.cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt;
    check_output("wrap_preload", bus.retire_cnt, 32'hFFFF_FFFF);
    apply_stimulus(3'b000, 1'b0, 1'b1, 32'd2, 32'd2, 5'd13);
    tick();
    idle();
    tick();
    check_output("wrap_out_data", bus.out_data, 32'd4);
    tick();
    check_output("wrap_retire", bus.retire_cnt, 32'd0);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
